// File: rtl/washer_disp_ctrl.sv
// Two-digit display controller for the washer: arbitrates error / mode preview / remaining time,
// converts the time to BCD with a sequential double-dabble and applies blinking.
module washer_disp_ctrl #(
   parameter int unsigned TICK_DIV  = 500000,
   parameter int unsigned MODE_HOLD = 6
) (
   input  logic       qclock,
   input  logic       rst_n,
   input  logic [6:0] time_val,
   input  logic       time_run,
   input  logic [3:0] mode_val,
   input  logic       mode_chg,
   input  logic [3:0] err_val,
   input  logic       err_act,
   output logic [3:0] code1,
   output logic [3:0] code2,
   output logic       busy
);

   localparam int unsigned TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned TIME_W   = 7;
   localparam int unsigned BCD_W    = 8;
   localparam int unsigned ITER_W   = 3;
   localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
   localparam logic [3:0]        HOLD_INIT = 4'(MODE_HOLD);
   localparam logic [TIME_W-1:0] TIME_MAX  = TIME_W'(99);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(TIME_W - 1);
   localparam logic [3:0]        CODE_ERR  = 4'hE;
   localparam logic [3:0]        CODE_BLK  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WRITE = 2'd2
   } cvt_state_t;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_wrap;
   logic              phase;
   logic [3:0]        hold_cnt;

   cvt_state_t        state;
   logic [TIME_W-1:0] time_clamp;
   logic [TIME_W-1:0] last_val;
   logic [TIME_W-1:0] shreg;
   logic [BCD_W-1:0]  bcd_acc;
   logic [ITER_W-1:0] iter;
   logic [2:0]        tens_adj;
   logic [3:0]        units_adj;
   logic [3:0]        tens;
   logic [3:0]        units;

   logic [3:0]        sel_code1;
   logic [3:0]        sel_code2;

   // Free-running blink generator; phase 1 means blank
   assign tick_wrap = (tick_cnt == TICK_MAX);

   always_ff @(posedge qclock or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         phase    <= 1'b0;
      end else if (tick_wrap) begin
         tick_cnt <= '0;
         phase    <= ~phase;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // Mode preview hold, counted in blink half-periods; a fresh load beats a toggle
   always_ff @(posedge qclock or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= 4'd0;
      end else if (mode_chg) begin
         hold_cnt <= HOLD_INIT;
      end else if (tick_wrap && (hold_cnt != 4'd0)) begin
         hold_cnt <= hold_cnt - 4'd1;
      end
   end

   assign time_clamp = (time_val > TIME_MAX) ? TIME_MAX : time_val;

   // Double-dabble adjust; the tens nibble only needs its low 3 bits since the
   // top bit is shifted out and the clamped value keeps it below 10
   always_comb begin
      tens_adj  = bcd_acc[6:4];
      units_adj = bcd_acc[3:0];
      if (bcd_acc[7:4] >= 4'd5) begin
         tens_adj = 3'(bcd_acc[6:4] + 3'd3);
      end
      if (bcd_acc[3:0] >= 4'd5) begin
         units_adj = 4'(bcd_acc[3:0] + 4'd3);
      end
   end

   // Binary-to-BCD converter
   always_ff @(posedge qclock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         last_val <= '0;
         shreg    <= '0;
         bcd_acc  <= '0;
         iter     <= '0;
         tens     <= 4'd0;
         units    <= 4'd0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (time_clamp != last_val) begin
                  shreg    <= time_clamp;
                  last_val <= time_clamp;
                  bcd_acc  <= '0;
                  iter     <= '0;
                  busy     <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_acc <= {tens_adj, units_adj, shreg[TIME_W-1]};
               shreg   <= {shreg[TIME_W-2:0], 1'b0};
               iter    <= iter + ITER_W'(1);
               if (iter == ITER_LAST) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               tens  <= bcd_acc[7:4];
               units <= bcd_acc[3:0];
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Source priority: error, then mode preview, then remaining time
   always_comb begin
      sel_code1 = CODE_BLK;
      sel_code2 = CODE_BLK;
      if (err_act) begin
         if (!phase) begin
            sel_code1 = CODE_ERR;
            sel_code2 = err_val;
         end
      end else if (hold_cnt != 4'd0) begin
         sel_code1 = 4'd0;
         sel_code2 = mode_val;
      end else if (!(phase && !time_run && ({tens, units} != 8'd0))) begin
         sel_code1 = tens;
         sel_code2 = units;
      end
   end

   always_ff @(posedge qclock or negedge rst_n) begin
      if (!rst_n) begin
         code1 <= CODE_BLK;
         code2 <= CODE_BLK;
      end else begin
         code1 <= sel_code1;
         code2 <= sel_code2;
      end
   end

endmodule

// File: tb/tb_washer_disp_ctrl.sv
// Directed bench for washer_disp_ctrl with TICK_DIV=4, MODE_HOLD=2.
module tb_washer_disp_ctrl;

   logic       qclock;
   logic       rst_n;
   logic [6:0] time_val;
   logic       time_run;
   logic [3:0] mode_val;
   logic       mode_chg;
   logic [3:0] err_val;
   logic       err_act;
   logic [3:0] code1;
   logic [3:0] code2;
   logic       busy;

   int checks;
   int failures;
   int cyc;

   washer_disp_ctrl #(
      .TICK_DIV  (4),
      .MODE_HOLD (2)
   ) dut (
      .qclock   (qclock),
      .rst_n    (rst_n),
      .time_val (time_val),
      .time_run (time_run),
      .mode_val (mode_val),
      .mode_chg (mode_chg),
      .err_val  (err_val),
      .err_act  (err_act),
      .code1    (code1),
      .code2    (code2),
      .busy     (busy)
   );

   initial begin
      qclock = 1'b0;
      forever #5 qclock = ~qclock;
   end

   // Edges since reset release; blink phase seen on the outputs after edge k is ((k-1)/4)%2
   always @(posedge qclock or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_code(input string tag, input logic [3:0] e1, input logic [3:0] e2);
      chk({tag, ".code1"}, code1, e1);
      chk({tag, ".code2"}, code2, e2);
   endtask

   task automatic chk_busy(input string tag, input logic expv);
      chk({tag, ".busy"}, {3'b000, busy}, {3'b000, expv});
   endtask

   task automatic tick();
      @(posedge qclock);
      @(negedge qclock);
   endtask

   function automatic logic exp_blank();
      return (((cyc - 1) / 4) % 2) == 1;
   endfunction

   task automatic chk_blink(input string tag, input logic [3:0] e1, input logic [3:0] e2);
      if (exp_blank()) chk_code(tag, 4'hF, 4'hF);
      else             chk_code(tag, e1, e2);
   endtask

   // Step to a negedge where the next edge index is congruent to r+1 mod 4
   task automatic align(input int r);
      while ((cyc % 4) != r) tick();
   endtask

   // Apply a new time value; busy must last exactly 8 cycles, digits one cycle later
   task automatic convert(input string tag, input logic [6:0] v, input logic [3:0] e1, input logic [3:0] e2);
      int n;
      time_val = v;
      tick();
      chk_busy({tag, ".start"}, 1'b1);
      n = 0;
      while (busy === 1'b1 && n < 12) begin
         tick();
         n++;
      end
      chk({tag, ".busylen"}, 4'(n), 4'd8);
      tick();
      chk_code({tag, ".digits"}, e1, e2);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      time_val = 7'd0;
      time_run = 1'b0;
      mode_val = 4'd0;
      mode_chg = 1'b0;
      err_val  = 4'd0;
      err_act  = 1'b0;

      // Reset and release with time 0
      repeat (3) @(negedge qclock);
      chk_code("reset", 4'hF, 4'hF);
      chk_busy("reset", 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_code("post_reset", 4'd0, 4'd0);
         chk_busy("post_reset", 1'b0);
      end

      // Conversion with program running, clamp, and no-change after clamp
      time_run = 1'b1;
      convert("conv73", 7'd73, 4'd7, 4'd3);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_code("steady73", 4'd7, 4'd3);
      end
      convert("conv120", 7'd120, 4'd9, 4'd9);
      time_val = 7'd99;
      tick();
      chk_busy("clamp_same", 1'b0);
      tick();
      chk_code("clamp_same", 4'd9, 4'd9);

      // Paused blinking, then finished 00 steady
      convert("conv73b", 7'd73, 4'd7, 4'd3);
      time_run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_blink("pause_blink", 4'd7, 4'd3);
      end
      time_val = 7'd0;
      repeat (10) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_code("finished00", 4'd0, 4'd0);
      end

      // Mode preview, pulse right after a toggle
      time_run = 1'b1;
      convert("conv73c", 7'd73, 4'd7, 4'd3);
      align(0);
      mode_val = 4'd5;
      mode_chg = 1'b1;
      tick();
      mode_chg = 1'b0;
      chk_code("mode_lat", 4'd7, 4'd3);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_code("mode_hold", 4'd0, 4'd5);
      end
      tick();
      chk_code("mode_end", 4'd7, 4'd3);

      // Pulse coincident with a phase toggle: load wins
      align(3);
      mode_chg = 1'b1;
      tick();
      mode_chg = 1'b0;
      chk_code("loadwin_lat", 4'd7, 4'd3);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_code("loadwin_hold", 4'd0, 4'd5);
      end
      tick();
      chk_code("loadwin_end", 4'd7, 4'd3);

      // Second pulse mid-hold extends the preview
      align(0);
      mode_chg = 1'b1;
      tick();
      mode_chg = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_code("ext_first", 4'd0, 4'd5);
      end
      mode_chg = 1'b1;
      tick();
      mode_chg = 1'b0;
      chk_code("ext_reload", 4'd0, 4'd5);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_code("ext_hold", 4'd0, 4'd5);
      end
      tick();
      chk_code("ext_end", 4'd7, 4'd3);

      // Error over time display, then release
      err_val = 4'd4;
      err_act = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_blink("err_time", 4'hE, 4'd4);
      end
      err_act = 1'b0;
      tick();
      chk_code("err_time_drop", 4'd7, 4'd3);

      // Error over mode preview; the hold still runs underneath
      align(0);
      mode_chg = 1'b1;
      err_act  = 1'b1;
      tick();
      mode_chg = 1'b0;
      chk_blink("err_mode", 4'hE, 4'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_blink("err_mode", 4'hE, 4'd4);
      end
      err_act = 1'b0;
      tick();
      chk_code("err_mode_drop", 4'd0, 4'd5);
      tick();
      chk_code("err_mode_hold", 4'd0, 4'd5);
      tick();
      chk_code("err_mode_end", 4'd7, 4'd3);

      // Input change mid-conversion is deferred to the next IDLE
      convert("conv0", 7'd0, 4'd0, 4'd0);
      time_val = 7'd73;
      tick();
      chk_busy("defer_start", 1'b1);
      repeat (3) tick();
      time_val = 7'd41;
      repeat (5) tick();
      chk_busy("defer_write", 1'b0);
      chk_code("defer_old", 4'd0, 4'd0);
      tick();
      chk_code("defer_73", 4'd7, 4'd3);
      chk_busy("defer_restart", 1'b1);
      repeat (8) tick();
      chk_busy("defer_done", 1'b0);
      tick();
      chk_code("defer_41", 4'd4, 4'd1);

      // Asynchronous reset mid-conversion, re-conversion after release
      convert("conv0b", 7'd0, 4'd0, 4'd0);
      time_val = 7'd41;
      tick();
      chk_busy("rst_mid_start", 1'b1);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk_code("rst_async", 4'hF, 4'hF);
      chk_busy("rst_async", 1'b0);
      @(negedge qclock);
      rst_n = 1'b1;
      tick();
      chk_busy("reconv_start", 1'b1);
      chk_code("reconv_start", 4'd0, 4'd0);
      repeat (8) tick();
      chk_busy("reconv_done", 1'b0);
      tick();
      chk_code("reconv_41", 4'd4, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/washer_disp_ctrl.md
# washer_disp_ctrl

Display controller for the washer's two-digit seven-segment unit. It arbitrates between three display sources: error code, mode preview and remaining wash time. It converts remaining time from binary to BCD with a sequential shift-add converter and applies blinking. Its outputs drive the `code1`/`code2` inputs of the two-digit multiplexed display driver, and it runs on the same `qclock`.

## Interface
Parameters:
- `TICK_DIV`, default 500000: `qclock` cycles per blink half-period (≥2).
- `MODE_HOLD`, default 6: number of blink half-periods the mode preview is held after a mode change (1..15).

Ports:
- `qclock`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `time_val`  in  7  remaining minutes, binary 0..127; values >99 are clamped to 99.
- `time_run`  in  1  level, 1 = wash program running, 0 = paused/stopped.
- `mode_val`  in  4  selected program number 0..9.
- `mode_chg`  in  1  single-cycle pulse, mode changed.
- `err_val`  in  4  error number 0..9.
- `err_act`  in  1  level, error condition active.
- `code1`  out  4  tens digit code, registered; 0..9 digit, 4'hE error marker, 4'hF blank.
- `code2`  out  4  units digit code, registered; same encoding.
- `busy`  out  1  BCD conversion in progress.

## Operation
- Reset values:
  - `code1` = `code2` = 4'hF, `busy` = 0.
  - Blink phase 0 (visible), tick counter 0, mode-hold counter 0.
  - `tens` = `units` = 0, last-converted value 0, converter FSM in IDLE.
- Blink generator:
  - Tick counter counts 0..TICK_DIV-1, then wraps to 0.
  - On wrap the phase toggles (0 visible, 1 blank).
  - Runs continuously and is never reset by source changes.
- Mode hold:
  - `mode_chg` loads the counter with MODE_HOLD; a new pulse during a hold reloads it.
  - The counter decrements on each phase toggle while nonzero.
  - If a load and a toggle happen in the same cycle, the load wins.
- Converter FSM, states IDLE, SHIFT, WRITE:
  - IDLE: if clamped `time_val` ≠ last-converted value, latch clamped value into shift register and into last-converted value, clear BCD accumulator, set iteration count 0, `busy`←1, go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle (add 3 to any BCD nibble ≥5, then shift left 1). After 7 iterations go to WRITE.
  - WRITE: copy accumulator to `tens`/`units`, `busy`←0, go to IDLE.
  - `time_val` changes during SHIFT/WRITE are ignored and picked up on the next IDLE cycle.
- Source select, priority highest first:
  1. `err_act` = 1: `code1` = 4'hE, `code2` = `err_val`. Both 4'hF during phase 1.
  2. Mode-hold counter ≠ 0: `code1` = 0, `code2` = `mode_val`. No blinking.
  3. Otherwise, time display: `code1` = `tens`, `code2` = `units`. Blinks (phase 1 → both 4'hF) when `time_run` = 0 and `tens`:`units` ≠ 00. Steady when running, or when the displayed value is 00 (program finished).
- `mode_chg` while `err_act` = 1: hold counter still loads and counts, but the error is displayed.
- `rst_n` low mid-conversion aborts immediately to the reset values. The value is re-converted after release if `time_val` ≠ 0.

## Timing
- Conversion: clamped `time_val` differs in IDLE at edge N → `busy` = 1 after N. Shifts at N+1..N+7, WRITE at N+8 (`busy` = 0 after N+8), new digits on `code1`/`code2` after N+9.
- Source select and blink: `code1`/`code2` reflect select inputs (`err_act`, `err_val`, `mode_val`, hold counter, phase, `time_run`) one cycle after they change.
- `mode_chg` at edge M → preview visible after M+1.
- Preview length: between MODE_HOLD−1 and MODE_HOLD full half-periods plus the partial half-period in progress.
- Blink period: 2·TICK_DIV cycles, 50% duty.

## Test plan
All scenarios run with TICK_DIV = 4 and MODE_HOLD = 2.
- Reset, then release with `time_val` = 0 → `code1`/`code2` = F/F during reset, 0/0 one cycle after release, `busy` never 1.
- `time_val` = 73, `time_run` = 1 → `busy` high for 8 cycles, then `code1` = 7, `code2` = 3, steady. `time_val` = 120 → 9/9.
- `time_run` = 0 with 7/3 displayed → outputs alternate 7/3 and F/F every 4 cycles. Set `time_val` = 0 → steady 0/0.
- `mode_chg` pulse with `mode_val` = 5 → 0/5 shown, returning to time display after 2 phase toggles. A second pulse mid-hold extends the preview.
- `err_act` = 1, `err_val` = 4, during both mode preview and time display → E/4 alternating with F/F. Drop `err_act` → previous source resumes the next cycle.
- `time_val` 73→41 at 3 cycles into a conversion, then `rst_n` pulsed low mid-conversion → 7/3 completes, then 4/1 follows. Reset forces F/F and `busy` = 0 asynchronously, and re-conversion of 41 starts after release.
